// File: rtl/gp_pkg.sv
// Shared types and constants for the block-buffer slice: the cipher block width and its block type.
package gp_pkg;
    localparam int GP_BLOCK_W = 128;
    typedef logic [GP_BLOCK_W-1:0] gp_block_t;
endpackage

// File: rtl/gp_buf_mem.sv
// Block storage for gp_block_buffer: DEPTH x WIDTH array, one synchronous write port and one
// asynchronous read port so the head block is visible in the same cycle its address is presented.
module gp_buf_mem
    import gp_pkg::*;
#(
    parameter int WIDTH = GP_BLOCK_W,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    // Contents are deliberately not reset; the buffer masks data_o while empty.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/gp_block_buffer.sv
// Show-ahead block FIFO between a cipher core and its consumer, with sticky overflow and busy back-pressure.
// Optional statistics counters (blocks_in_o, blocks_out_o, drops_o) are built when GP_BUF_STATS_EN is defined.
module gp_block_buffer
    import gp_pkg::*;
#(
    parameter int WIDTH     = GP_BLOCK_W,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     valid_i,
    output logic                     busy_o,
    input  logic                     clear_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    input  logic                     ack_i,
    output logic [$clog2(DEPTH):0]   level_o,
`ifdef GP_BUF_STATS_EN
    output logic [31:0]              blocks_in_o,
    output logic [31:0]              blocks_out_o,
    output logic [31:0]              drops_o,
`endif
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Handshake: a push is offered whenever valid_i=1 and is accepted unless the buffer is full
    // with no same-cycle pop (then it is dropped and overflow_o latches); a pop happens when
    // ack_i=1 and valid_o=1. busy_o is advisory back-pressure raised early by AF_MARGIN slots.
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [LW-1:0]    level;
    logic [LW-1:0]    free_slots;
    logic             empty, full;
    logic             push, pop, drop;
    logic [WIDTH-1:0] rdata;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign free_slots = LW'(DEPTH) - level;
    assign empty      = (level == '0);
    assign full       = (level == LW'(DEPTH));

    assign pop  = ack_i & ~empty & ~clear_i;
    assign push = valid_i & ~clear_i & (~full | pop);
    assign drop = valid_i & ~clear_i & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + LW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + LW'(1);
            if (drop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    gp_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rdata)
    );

    assign valid_o    = ~empty;
    assign data_o     = empty ? '0 : rdata;
    assign level_o    = level;
    assign busy_o     = (free_slots <= LW'(AF_MARGIN));
    assign overflow_o = overflow_q;

`ifdef GP_BUF_STATS_EN
    logic [31:0] blocks_in_q, blocks_in_d;
    logic [31:0] blocks_out_q, blocks_out_d;
    logic [31:0] drops_q, drops_d;

    always_comb begin
        blocks_in_d  = blocks_in_q;
        blocks_out_d = blocks_out_q;
        drops_d      = drops_q;
        if (clear_i) begin
            blocks_in_d  = '0;
            blocks_out_d = '0;
            drops_d      = '0;
        end else begin
            if (push) blocks_in_d  = blocks_in_q + 32'd1;
            if (pop)  blocks_out_d = blocks_out_q + 32'd1;
            if (drop) drops_d      = drops_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blocks_in_q  <= '0;
            blocks_out_q <= '0;
            drops_q      <= '0;
        end else begin
            blocks_in_q  <= blocks_in_d;
            blocks_out_q <= blocks_out_d;
            drops_q      <= drops_d;
        end
    end

    assign blocks_in_o  = blocks_in_q;
    assign blocks_out_o = blocks_out_q;
    assign drops_o      = drops_q;
`endif
endmodule
